tap_ir_ctrl: RTL and testbench
==============================

Name: tap_ir_ctrl

Overview:
- IEEE 1149.1 TAP controller plus instruction register.
- Sits directly upstream of the instruction decoder and drives its instr_in bus.
- Runs the 16-state TAP FSM from tms and shifts the IR from tdi.
- Presents the updated instruction plus DR capture/shift/update strobes to the boundary-scan chains.
- Muxes tdo between the IR shift stage and the selected chain's serial output.

Parameters:
- instr_width, 4: IR length; must equal the decoder's instr_width; legal range 3..16.

Ports:
- clk  input  1  TCK; all state updates on the rising edge.
- reset  input  1  async active-high; forces Test-Logic-Reset.
- tms  input  1  test mode select; sampled on the rising edge of clk.
- tdi  input  1  serial data in.
- dr_tdo  input  1  serial out of the currently selected data register/chain.
- tdo  output  1  serial data out.
- tdo_en  output  1  high while in Shift-IR or Shift-DR.
- instr_out  output  instr_width  updated instruction; feeds the decoder's instr_in.
- capture_dr  output  1  high while in Capture-DR.
- shift_dr  output  1  high while in Shift-DR.
- update_dr  output  1  high while in Update-DR.
- tap_reset  output  1  high while in Test-Logic-Reset.

Behaviour:
- FSM states and transitions (tms=0 / tms=1):
  - TLR: RTI / TLR
  - RTI: RTI / SelDR
  - SelDR: CapDR / SelIR
  - CapDR: ShDR / Ex1DR
  - ShDR: ShDR / Ex1DR
  - Ex1DR: PauseDR / UpdDR
  - PauseDR: PauseDR / Ex2DR
  - Ex2DR: ShDR / UpdDR
  - UpdDR: RTI / SelDR
  - SelIR: CapIR / TLR
  - CapIR: ShIR / Ex1IR
  - ShIR: ShIR / Ex1IR
  - Ex1IR: PauseIR / UpdIR
  - PauseIR: PauseIR / Ex2IR
  - Ex2IR: ShIR / UpdIR
  - UpdIR: RTI / SelDR
- State encoding: 4-bit enum; one state register.
- Guaranteed recovery: five consecutive tms=1 clocks reach TLR from any state.
- Reset, asserted at any time including mid-shift:
  - State goes to TLR immediately.
  - ir_shift clears to 0.
  - instr_out goes to 0 (the bypass encoding).
  - All strobes go to 0 except tap_reset, which goes to 1.
  - tdo=0, tdo_en=0.
- IR shift register (ir_shift, instr_width bits):
  - In CapIR: loads {zeros, 2'b01} (mandatory LSB pattern).
  - In ShIR: each clock does ir_shift <= {tdi, ir_shift[instr_width-1:1]}; LSB is shifted out first.
  - In all other states: holds.
- instr_out:
  - Loads ir_shift on the rising edge that leaves UpdIR, i.e. the edge on which state==UpdIR.
  - Visible the cycle after UpdIR.
  - Holds in every other state, so partial shifts and Pause never disturb the decoder.
- Entering TLR (by tms or by reset) loads instr_out with 0, the bypass code.
- Strobes are pure decodes of the current state register: 1 cycle wide, glitch-free, no extra latency.
- tdo is combinational:
  - ShIR: ir_shift[0]
  - ShDR: dr_tdo
  - otherwise: 0
- tdo_en = (state==ShIR) | (state==ShDR).
- Shift counts:
  - An N-bit IR scan with N>instr_width keeps only the last instr_width bits of tdi.
  - N<instr_width leaves capture-pattern bits in the upper positions; no error flag.
- Corner cases:
  - A DR scan never alters instr_out.
  - A tms sequence that passes through UpdIR without any ShIR updates instr_out with the captured pattern {0..0,01}. This is the defined behaviour and is decoded as intest.

Optional Feature:
- Macro: TAP_STATE_DBG_EN.
- With it defined:
  - Adds output port tap_state (4 bits) carrying the current FSM encoding.
  - Adds an output ir_scan_err (1 bit): sticky, set when UpdIR is reached with a shift count other than instr_width since CapIR.
  - ir_scan_err clears in TLR and on reset.
  - Adds a 5-bit saturating shift counter.
- Without it: neither port nor the counter exists; all other behaviour is identical.

Decomposition:
- Package tap_pkg holds:
  - the tap_state_t enum (16 states, 4 bits);
  - IR_CAPTURE_LSB = 2'b01;
  - the BYPASS code (all zeros).
  The decoder also imports this package.
- One sub-module, tap_fsm: pure state register plus next-state logic, tms in / state out.
- tap_ir_ctrl instantiates tap_fsm and holds the IR, the tdo mux and the strobe decode.

Test Plan:
- Reset mid-ShIR after 2 shifted bits -> next sample: tap_reset=1, instr_out=4'b0000, tdo_en=0; then tms=0 -> RTI, tap_reset=0.
- From RTI: tms 1,1,0,0, shift tdi 1,1,0,1 (LSB first, tms=1 on last bit), then tms 1,0:
  - tdo during the shift reads 1,0,0,0 (the capture pattern);
  - instr_out=4'b1011 one cycle after UpdIR.
- Scan 6 bits 1,0,1,1,0,0 into IR -> instr_out=4'b0011 (the last 4 bits shifted).
- DR scan (tms 1,0,0, 3 shifts, 1,1):
  - capture_dr, then 3 shift_dr cycles, then update_dr, each 1 cycle;
  - tdo follows dr_tdo while shifting;
  - instr_out unchanged.
- Pause: from ShIR go to PauseIR for 5 cycles, then Ex2IR, then resume ShIR -> ir_shift contents preserved; final instr_out matches the uninterrupted scan.
- From each of the 16 states, drive tms=1 for 5 clocks -> state TLR and instr_out=0; with TAP_STATE_DBG_EN, tap_state equals the TLR encoding.

Source files
------------

// File: rtl/tap_pkg.sv
// Shared TAP definitions for the controller and the instruction decoder.
//   tap_state_t    : 4-bit encoding of the 16 IEEE 1149.1 TAP states
//   IR_CAPTURE_LSB : fixed pattern loaded into the IR LSBs in Capture-IR
//   BYPASS         : all-zeros instruction, sliced to instr_width by users
package tap_pkg;

   typedef enum logic [3:0] {
      ST_EX2_DR   = 4'h0,
      ST_EX1_DR   = 4'h1,
      ST_SH_DR    = 4'h2,
      ST_PAUSE_DR = 4'h3,
      ST_SEL_IR   = 4'h4,
      ST_UPD_DR   = 4'h5,
      ST_CAP_DR   = 4'h6,
      ST_SEL_DR   = 4'h7,
      ST_EX2_IR   = 4'h8,
      ST_EX1_IR   = 4'h9,
      ST_SH_IR    = 4'hA,
      ST_PAUSE_IR = 4'hB,
      ST_RTI      = 4'hC,
      ST_UPD_IR   = 4'hD,
      ST_CAP_IR   = 4'hE,
      ST_TLR      = 4'hF
   } tap_state_t;

   localparam logic [1:0]  IR_CAPTURE_LSB = 2'b01;
   localparam logic [15:0] BYPASS         = 16'h0000;

endpackage

// File: rtl/tap_ir_ctrl_if.sv
// Serial and strobe bundle between the TAP pins / scan chains and tap_ir_ctrl.
//   tms, tdi, dr_tdo       : driven by the master (pins and selected chain)
//   tdo, tdo_en, instr_out : driven by the slave (controller)
//   capture_dr, shift_dr, update_dr, tap_reset : state-decoded strobes
// Build option TAP_STATE_DBG_EN adds tap_state and ir_scan_err.
interface tap_ir_ctrl_if #(
   parameter int instr_width = 4
);
   logic                   tms;
   logic                   tdi;
   logic                   dr_tdo;
   logic                   tdo;
   logic                   tdo_en;
   logic [instr_width-1:0] instr_out;
   logic                   capture_dr;
   logic                   shift_dr;
   logic                   update_dr;
   logic                   tap_reset;
`ifdef TAP_STATE_DBG_EN
   logic [3:0]             tap_state;
   logic                   ir_scan_err;

   modport master (
      output tms, tdi, dr_tdo,
      input  tdo, tdo_en, instr_out, capture_dr, shift_dr, update_dr,
             tap_reset, tap_state, ir_scan_err
   );
   modport slave (
      input  tms, tdi, dr_tdo,
      output tdo, tdo_en, instr_out, capture_dr, shift_dr, update_dr,
             tap_reset, tap_state, ir_scan_err
   );
`else
   modport master (
      output tms, tdi, dr_tdo,
      input  tdo, tdo_en, instr_out, capture_dr, shift_dr, update_dr,
             tap_reset
   );
   modport slave (
      input  tms, tdi, dr_tdo,
      output tdo, tdo_en, instr_out, capture_dr, shift_dr, update_dr,
             tap_reset
   );
`endif
endinterface

// File: rtl/tap_fsm.sv
// IEEE 1149.1 TAP state machine: state register plus next-state logic only.
//   clk       : TCK, rising edge
//   reset     : async active-high, forces TLR
//   tms       : test mode select
//   state     : current state register
//   state_nxt : state that will be taken on the next rising edge
//
// state    | meaning
// ---------+---------------------------------------------
// TLR      | Test-Logic-Reset, test logic idle/bypass
// RTI      | Run-Test/Idle
// SEL_DR   | Select-DR-Scan
// CAP_DR   | Capture-DR, chain parallel load
// SH_DR    | Shift-DR, chain shifting tdi->dr_tdo
// EX1_DR   | Exit1-DR
// PAUSE_DR | Pause-DR, chain holds
// EX2_DR   | Exit2-DR
// UPD_DR   | Update-DR, chain parallel update
// SEL_IR   | Select-IR-Scan
// CAP_IR   | Capture-IR, IR loads capture pattern
// SH_IR    | Shift-IR, IR shifting tdi->tdo
// EX1_IR   | Exit1-IR
// PAUSE_IR | Pause-IR, IR holds
// EX2_IR   | Exit2-IR
// UPD_IR   | Update-IR, instruction latched on exit
module tap_fsm
   import tap_pkg::*;
(
   input  logic       clk,
   input  logic       reset,
   input  logic       tms,
   output tap_state_t state,
   output tap_state_t state_nxt
);

   tap_state_t state_q;
   tap_state_t state_d;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) state_q <= ST_TLR;
      else       state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      unique case (state_q)
         ST_TLR:      state_d = tms ? ST_TLR      : ST_RTI;
         ST_RTI:      state_d = tms ? ST_SEL_DR   : ST_RTI;
         ST_SEL_DR:   state_d = tms ? ST_SEL_IR   : ST_CAP_DR;
         ST_CAP_DR:   state_d = tms ? ST_EX1_DR   : ST_SH_DR;
         ST_SH_DR:    state_d = tms ? ST_EX1_DR   : ST_SH_DR;
         ST_EX1_DR:   state_d = tms ? ST_UPD_DR   : ST_PAUSE_DR;
         ST_PAUSE_DR: state_d = tms ? ST_EX2_DR   : ST_PAUSE_DR;
         ST_EX2_DR:   state_d = tms ? ST_UPD_DR   : ST_SH_DR;
         ST_UPD_DR:   state_d = tms ? ST_SEL_DR   : ST_RTI;
         ST_SEL_IR:   state_d = tms ? ST_TLR      : ST_CAP_IR;
         ST_CAP_IR:   state_d = tms ? ST_EX1_IR   : ST_SH_IR;
         ST_SH_IR:    state_d = tms ? ST_EX1_IR   : ST_SH_IR;
         ST_EX1_IR:   state_d = tms ? ST_UPD_IR   : ST_PAUSE_IR;
         ST_PAUSE_IR: state_d = tms ? ST_EX2_IR   : ST_PAUSE_IR;
         ST_EX2_IR:   state_d = tms ? ST_UPD_IR   : ST_SH_IR;
         ST_UPD_IR:   state_d = tms ? ST_SEL_DR   : ST_RTI;
         default:     state_d = ST_TLR;
      endcase
   end

   assign state     = state_q;
   assign state_nxt = state_d;

endmodule

// File: rtl/tap_ir_ctrl.sv
// TAP controller plus instruction register, feeding the instruction decoder.
//   clk   : TCK, all state updates on the rising edge
//   reset : async active-high, forces TLR and the bypass instruction
//   tap   : tap_ir_ctrl_if slave modport
//             in : tms, tdi, dr_tdo
//             out: tdo, tdo_en, instr_out, capture_dr, shift_dr, update_dr,
//                  tap_reset
// Build option TAP_STATE_DBG_EN adds tap_state (current encoding) and the
// sticky ir_scan_err flag backed by a 5-bit saturating shift counter.
module tap_ir_ctrl
   import tap_pkg::*;
#(
   parameter int instr_width = 4
) (
   input  logic         clk,
   input  logic         reset,
   tap_ir_ctrl_if.slave tap
);

   localparam logic [instr_width-1:0] INSTR_BYPASS = BYPASS[instr_width-1:0];
   localparam logic [instr_width-1:0] IR_CAPTURE   =
      {{(instr_width-2){1'b0}}, IR_CAPTURE_LSB};

   tap_state_t state_q;
   tap_state_t state_nxt;

   logic [instr_width-1:0] ir_shift_q, ir_shift_d;
   logic [instr_width-1:0] instr_q,    instr_d;
   logic                   tdo;

   tap_fsm u_fsm (
      .clk       (clk),
      .reset     (reset),
      .tms       (tap.tms),
      .state     (state_q),
      .state_nxt (state_nxt)
   );

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         ir_shift_q <= '0;
         instr_q    <= INSTR_BYPASS;
      end else begin
         ir_shift_q <= ir_shift_d;
         instr_q    <= instr_d;
      end
   end

   always_comb begin
      ir_shift_d = ir_shift_q;
      instr_d    = instr_q;
      unique case (state_q)
         ST_CAP_IR: ir_shift_d = IR_CAPTURE;
         ST_SH_IR:  ir_shift_d = {tap.tdi, ir_shift_q[instr_width-1:1]};
         ST_UPD_IR: instr_d    = ir_shift_q;
         default:   ;
      endcase
      // Clear on the edge that enters TLR so the decoder sees bypass as soon
      // as the state register shows TLR, not one cycle later.
      if (state_nxt == ST_TLR) instr_d = INSTR_BYPASS;
   end

   always_comb begin
      tdo = 1'b0;
      unique case (state_q)
         ST_SH_IR: tdo = ir_shift_q[0];
         ST_SH_DR: tdo = tap.dr_tdo;
         default:  tdo = 1'b0;
      endcase
   end

   assign tap.tdo        = tdo;
   assign tap.tdo_en     = (state_q == ST_SH_IR) | (state_q == ST_SH_DR);
   assign tap.instr_out  = instr_q;
   assign tap.capture_dr = (state_q == ST_CAP_DR);
   assign tap.shift_dr   = (state_q == ST_SH_DR);
   assign tap.update_dr  = (state_q == ST_UPD_DR);
   assign tap.tap_reset  = (state_q == ST_TLR);

`ifdef TAP_STATE_DBG_EN
   localparam logic [4:0] SHIFT_TARGET = 5'(instr_width);

   logic [4:0] shift_cnt_q, shift_cnt_d;
   logic       scan_err_q,  scan_err_d;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         shift_cnt_q <= '0;
         scan_err_q  <= 1'b0;
      end else begin
         shift_cnt_q <= shift_cnt_d;
         scan_err_q  <= scan_err_d;
      end
   end

   always_comb begin
      shift_cnt_d = shift_cnt_q;
      scan_err_d  = scan_err_q;
      if (state_q == ST_CAP_IR) begin
         shift_cnt_d = '0;
      end else if (state_q == ST_SH_IR && shift_cnt_q != 5'd31) begin
         shift_cnt_d = shift_cnt_q + 5'd1;
      end
      if (state_q == ST_TLR) begin
         scan_err_d = 1'b0;
      end else if (state_q == ST_UPD_IR && shift_cnt_q != SHIFT_TARGET) begin
         scan_err_d = 1'b1;
      end
   end

   assign tap.tap_state   = state_q;
   assign tap.ir_scan_err = scan_err_q;
`endif

endmodule

// File: tb/tb_tap_ir_ctrl.sv
module tb_tap_ir_ctrl;
   import tap_pkg::*;

   localparam int IW = 4;

   logic clk;
   logic reset;
   int   n_checks;
   int   n_errors;

   tap_ir_ctrl_if #(.instr_width(IW)) tb_if ();

   tap_ir_ctrl #(.instr_width(IW)) dut (
      .clk   (clk),
      .reset (reset),
      .tap   (tb_if)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #300000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Apply tms/tdi, clock once, sample 1 time unit after the edge.
   task automatic tck(input logic t_tms, input logic t_tdi = 1'b0);
      tb_if.tms = t_tms;
      tb_if.tdi = t_tdi;
      @(posedge clk);
      #1;
   endtask

   // From RTI: full IR scan of n bits (LSB first), ending back in RTI.
   task automatic scan_ir(input logic [15:0] bits, input int n);
      tck(1'b1); tck(1'b1); tck(1'b0); tck(1'b0);
      for (int i = 0; i < n; i++) tck(i == n - 1, bits[i]);
      tck(1'b1);
      tck(1'b0);
   endtask

   tap_state_t tgt   [16] = '{ST_TLR, ST_RTI, ST_SEL_DR, ST_CAP_DR, ST_SH_DR,
                              ST_EX1_DR, ST_PAUSE_DR, ST_EX2_DR, ST_UPD_DR,
                              ST_SEL_IR, ST_CAP_IR, ST_SH_IR, ST_EX1_IR,
                              ST_PAUSE_IR, ST_EX2_IR, ST_UPD_IR};
   int         plen  [16] = '{3, 0, 1, 2, 3, 3, 4, 5, 4, 2, 3, 4, 4, 5, 6, 5};
   logic [7:0] pbits [16] = '{8'b111, 8'b0, 8'b1, 8'b01, 8'b001, 8'b101,
                              8'b0101, 8'b10101, 8'b1101, 8'b11, 8'b011,
                              8'b0011, 8'b1011, 8'b01011, 8'b101011, 8'b11011};

   initial begin
      logic [4:0] exp_strb;
      logic [3:0] dr_pat;
      n_checks     = 0;
      n_errors     = 0;
      reset        = 1'b1;
      tb_if.tms    = 1'b1;
      tb_if.tdi    = 1'b0;
      tb_if.dr_tdo = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      chk("rst_tap_reset", 32'(tb_if.tap_reset), 32'd1);
      chk("rst_instr",     32'(tb_if.instr_out), 32'h0);
      chk("rst_tdo_en",    32'(tb_if.tdo_en),    32'd0);
      chk("rst_tdo",       32'(tb_if.tdo),       32'd0);
      reset = 1'b0;
      tck(1'b1);
      chk("tlr_hold", 32'(tb_if.tap_reset), 32'd1);

      // IR scan 1,1,0,1 -> 4'b1011; tdo shows the capture pattern 1,0,0,0
      tck(1'b0);
      chk("rti_tap_reset", 32'(tb_if.tap_reset), 32'd0);
      tck(1'b1); tck(1'b1); tck(1'b0); tck(1'b0);
      chk("shir_tdo_en", 32'(tb_if.tdo_en), 32'd1);
      dr_pat = 4'b0001;
      for (int i = 0; i < 4; i++) begin
         chk($sformatf("cap_tdo%0d", i), 32'(tb_if.tdo), 32'(dr_pat[i]));
         tck(i == 3, (i == 2) ? 1'b0 : 1'b1);
      end
      tck(1'b1);
      chk("updir_hold", 32'(tb_if.instr_out), 32'h0);
      tck(1'b0);
      chk("ir_1011", 32'(tb_if.instr_out), 32'hB);
`ifdef TAP_STATE_DBG_EN
      chk("err_clean", 32'(tb_if.ir_scan_err), 32'd0);
`endif

      // 6-bit scan keeps only the last 4 bits
      scan_ir(16'b001101, 6);
      chk("ir_6bit", 32'(tb_if.instr_out), 32'h3);
`ifdef TAP_STATE_DBG_EN
      chk("err_6bit", 32'(tb_if.ir_scan_err), 32'd1);
`endif

      // DR scan: strobes, tdo follows dr_tdo, instr_out untouched
      tck(1'b1); tck(1'b0);
      chk("capdr_strobe", 32'(tb_if.capture_dr), 32'd1);
      chk("capdr_shift",  32'(tb_if.shift_dr),   32'd0);
      tck(1'b0);
      dr_pat = 4'b0101;
      for (int k = 0; k < 3; k++) begin
         tb_if.dr_tdo = dr_pat[k];
         #1;
         chk($sformatf("shdr_strobe%0d", k), 32'(tb_if.shift_dr), 32'd1);
         chk($sformatf("shdr_tdo%0d", k), 32'(tb_if.tdo), 32'(dr_pat[k]));
         chk($sformatf("shdr_cap%0d", k), 32'(tb_if.capture_dr), 32'd0);
         tck(k == 2);
      end
      chk("ex1dr_shift", 32'(tb_if.shift_dr), 32'd0);
      chk("ex1dr_tdo_en", 32'(tb_if.tdo_en), 32'd0);
      tck(1'b1);
      chk("upddr_strobe", 32'(tb_if.update_dr), 32'd1);
      tck(1'b0);
      chk("rti_upd_clear", 32'(tb_if.update_dr), 32'd0);
      chk("dr_keeps_ir", 32'(tb_if.instr_out), 32'h3);
      tb_if.dr_tdo = 1'b0;

      // Paused IR scan 0,1 | pause x5 | 1,0 -> 4'b0110
      tck(1'b1); tck(1'b1); tck(1'b0); tck(1'b0);
      tck(1'b0, 1'b0);
      tck(1'b1, 1'b1);
      for (int p = 0; p < 5; p++) tck(1'b0);
      chk("pause_tdo_en", 32'(tb_if.tdo_en), 32'd0);
      chk("pause_instr",  32'(tb_if.instr_out), 32'h3);
      tck(1'b1); tck(1'b0);
      chk("resume_tdo", 32'(tb_if.tdo), 32'd0);
      tck(1'b0, 1'b1);
      tck(1'b1, 1'b0);
      tck(1'b1); tck(1'b0);
      chk("ir_pause", 32'(tb_if.instr_out), 32'h6);

      // UpdIR with no shifting latches the capture pattern
      tck(1'b1); tck(1'b1); tck(1'b0); tck(1'b1); tck(1'b1); tck(1'b0);
      chk("ir_noshift", 32'(tb_if.instr_out), 32'h1);

      // Async reset in the middle of an IR shift
      tck(1'b1); tck(1'b1); tck(1'b0); tck(1'b0);
      tck(1'b0, 1'b1); tck(1'b0, 1'b1);
      chk("midshift_en", 32'(tb_if.tdo_en), 32'd1);
      #2;
      reset = 1'b1;
      #1;
      chk("arst_tap_reset", 32'(tb_if.tap_reset), 32'd1);
      chk("arst_instr",     32'(tb_if.instr_out), 32'h0);
      chk("arst_tdo_en",    32'(tb_if.tdo_en),    32'd0);
      chk("arst_tdo",       32'(tb_if.tdo),       32'd0);
`ifdef TAP_STATE_DBG_EN
      chk("arst_err", 32'(tb_if.ir_scan_err), 32'd0);
`endif
      @(posedge clk);
      #1;
      reset = 1'b0;
      tck(1'b0);
      chk("arst_rti", 32'(tb_if.tap_reset), 32'd0);

      // Five tms=1 clocks from every state reach TLR with bypass loaded
      for (int s = 0; s < 16; s++) begin
         tck(1'b0);
         scan_ir(16'b1011, 4);
         chk($sformatf("pre_ir%0d", s), 32'(tb_if.instr_out), 32'hB);
         for (int j = 0; j < plen[s]; j++) tck(pbits[s][j]);
         exp_strb = {tgt[s] == ST_TLR, tgt[s] == ST_CAP_DR, tgt[s] == ST_SH_DR,
                     tgt[s] == ST_UPD_DR, (tgt[s] == ST_SH_DR) || (tgt[s] == ST_SH_IR)};
         chk($sformatf("strobes_st%0d", s),
             32'({tb_if.tap_reset, tb_if.capture_dr, tb_if.shift_dr,
                  tb_if.update_dr, tb_if.tdo_en}), 32'(exp_strb));
`ifdef TAP_STATE_DBG_EN
         chk($sformatf("dbg_st%0d", s), 32'(tb_if.tap_state), 32'(tgt[s]));
`endif
         for (int j = 0; j < 5; j++) tck(1'b1);
         chk($sformatf("rec_tlr%0d", s), 32'(tb_if.tap_reset), 32'd1);
         chk($sformatf("rec_ir%0d", s),  32'(tb_if.instr_out), 32'h0);
`ifdef TAP_STATE_DBG_EN
         chk($sformatf("rec_dbg%0d", s), 32'(tb_if.tap_state), 32'(ST_TLR));
`endif
      end

      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

endmodule
